hamming_stream_decoder: RTL and testbench

//  Parametrised streaming Hamming decoder; next generation of the fixed 7-bit combinational decoder_proj decoder.

---
 rtl/hamming_stream_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_hamming_stream_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_stream_decoder.sv
// Streaming Hamming decoder: valid/ready input, two-stage syndrome/correct
// pipeline, output FIFO with per-word status and saturating error counters.
module hamming_stream_decoder #(
  parameter int DATA_W     = 4,
  parameter int SECDED     = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8,
  localparam int P_MIN     = $clog2(DATA_W + 1),
  localparam int P         = ((1 << P_MIN) >= (DATA_W + P_MIN + 1)) ? P_MIN : P_MIN + 1,
  localparam int CW_W      = DATA_W + P + SECDED
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_status,
  output logic [P:0]        out_errpos,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  localparam int HAM_W = DATA_W + P;
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;

  // XOR of the 1-based positions of every set bit in the Hamming part.
  function automatic logic [P-1:0] calc_syn(input logic [CW_W-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int i = 0; i < HAM_W; i++) begin
      if (cw[i]) s = s ^ P'(i + 1);
    end
    return s;
  endfunction

  // Gather data bits from the non-power-of-2 positions, ascending.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int                k;
    d = '0;
    k = 0;
    for (int pos = 1; pos <= HAM_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos - 1];
        k    = k + 1;
      end
    end
    return d;
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              rdy_q, rdy_d;
  logic              accept;
  logic              vld_p1_q, vld_p1_d;
  logic [P-1:0]      syn_p1_q, syn_p1_d;
  logic              op_p1_q, op_p1_d;
  logic [CW_W-1:0]   cw_p1_q, cw_p1_d;

  logic [CW_W-1:0]   fix_cw;
  logic [1:0]        fix_status;
  logic [P:0]        fix_errpos;
  logic [DATA_W-1:0] fix_data;
  int                flip_pos;

  logic [DATA_W-1:0] data_mem   [FIFO_DEPTH];
  logic [1:0]        status_mem [FIFO_DEPTH];
  logic [P:0]        errpos_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push, pop;

  logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

  // Admission: the word in S1 is reserved a FIFO slot in advance, so a
  // pushed word always finds room without back-pressuring the pipeline.
  assign in_ready = rdy_q && ((int'(count_q) + int'(vld_p1_q)) < FIFO_DEPTH);
  assign accept   = in_valid && in_ready;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = vld_p1_q;

  // ---- Stage S1: syndrome and overall parity of the accepted word ----
  // Next-state for the S1 register.
  always_comb begin
    rdy_d    = 1'b1;
    vld_p1_d = accept;
    syn_p1_d = calc_syn(in_cw);
    op_p1_d  = ^in_cw;
    cw_p1_d  = in_cw;
  end

  // ---- Stage S2: correct, classify, push into the FIFO ----
  // Decide status and which bit (if any) to flip; uncorrectable words pass raw.
  always_comb begin
    fix_status = ST_CLEAN;
    fix_errpos = '0;
    flip_pos   = 0;
    if (SECDED != 0) begin
      if (op_p1_q) begin
        if (syn_p1_q == '0) begin
          // Only the overall-parity bit itself is wrong.
          flip_pos   = CW_W;
          fix_status = ST_CORR;
          fix_errpos = (P + 1)'(CW_W);
        end else if (int'(syn_p1_q) <= HAM_W) begin
          flip_pos   = int'(syn_p1_q);
          fix_status = ST_CORR;
          fix_errpos = {1'b0, syn_p1_q};
        end else begin
          // Odd parity but a syndrome pointing outside the word: cannot locate.
          fix_status = ST_UNCORR;
        end
      end else if (syn_p1_q != '0) begin
        fix_status = ST_UNCORR;
      end
    end else if (syn_p1_q != '0) begin
      if (int'(syn_p1_q) <= HAM_W) begin
        flip_pos   = int'(syn_p1_q);
        fix_status = ST_CORR;
        fix_errpos = {1'b0, syn_p1_q};
      end else begin
        fix_status = ST_UNCORR;
      end
    end
    fix_cw = cw_p1_q;
    for (int i = 0; i < CW_W; i++) begin
      if (flip_pos == i + 1) fix_cw[i] = ~cw_p1_q[i];
    end
    fix_data = extract_data(fix_cw);
  end

  // FIFO pointer/occupancy and error-counter next state; clear beats increment.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (clr_cnt) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (push) begin
      if (fix_status == ST_CORR)   cnt_corr_d   = sat_inc(cnt_corr_q);
      if (fix_status == ST_UNCORR) cnt_uncorr_d = sat_inc(cnt_uncorr_q);
    end
  end

  // Control state: valids, pointers, occupancy, counters, ready enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q        <= 1'b0;
      vld_p1_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      rdy_q        <= rdy_d;
      vld_p1_q     <= vld_p1_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  // Datapath registers: S1 payload and FIFO storage, qualified by the valids.
  always_ff @(posedge clock) begin
    syn_p1_q <= syn_p1_d;
    op_p1_q  <= op_p1_d;
    cw_p1_q  <= cw_p1_d;
    if (push) begin
      data_mem[wr_ptr_q]   <= fix_data;
      status_mem[wr_ptr_q] <= fix_status;
      errpos_mem[wr_ptr_q] <= fix_errpos;
    end
  end

  // Head of FIFO; forced to zero when empty so stale storage never shows.
  assign out_data   = out_valid ? data_mem[rd_ptr_q]   : '0;
  assign out_status = out_valid ? status_mem[rd_ptr_q] : '0;
  assign out_errpos = out_valid ? errpos_mem[rd_ptr_q] : '0;
  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Directed bench for hamming_stream_decoder: SEC instance with 2-bit counters
// and a SECDED instance with 8-bit counters, sharing clock and reset.
module tb_hamming_stream_decoder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr;
  logic [6:0] a_in_cw;
  logic [3:0] a_out_data, a_out_errpos;
  logic [1:0] a_out_status, a_cnt_corr, a_cnt_uncorr;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr;
  logic [7:0] b_in_cw;
  logic [3:0] b_out_data, b_out_errpos;
  logic [1:0] b_out_status;
  logic [7:0] b_cnt_corr, b_cnt_uncorr;

  int   checks = 0;
  int   errors = 0;
  int   acc;
  logic rdy;

  // Valid SEC codewords for data 1..6 (hand-encoded).
  logic [6:0] tbl_cw [6] = '{7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33};
  logic [3:0] tbl_d  [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};

  hamming_stream_decoder #(.DATA_W(4), .SECDED(0), .FIFO_DEPTH(4), .CNT_W(2)) u_sec (
    .clock(clock), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_cw(a_in_cw),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_status(a_out_status), .out_errpos(a_out_errpos),
    .clr_cnt(a_clr), .cnt_corr(a_cnt_corr), .cnt_uncorr(a_cnt_uncorr)
  );

  hamming_stream_decoder #(.DATA_W(4), .SECDED(1), .FIFO_DEPTH(4), .CNT_W(8)) u_ded (
    .clock(clock), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_cw(b_in_cw),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_status(b_out_status), .out_errpos(b_out_errpos),
    .clr_cnt(b_clr), .cnt_corr(b_cnt_corr), .cnt_uncorr(b_cnt_uncorr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with out_ready high: one word through the SEC decoder.
  task automatic a_xfer(input logic [6:0] cw, input logic [3:0] d,
                        input logic [1:0] st, input logic [3:0] ep);
    check("a_rdy", 32'(a_in_ready), 32'd1);
    a_in_valid = 1'b1;
    a_in_cw    = cw;
    @(posedge clock);
    #1 a_in_valid = 1'b0;
    @(negedge clock);
    check("a_lat", 32'(a_out_valid), 32'd0);
    @(negedge clock);
    check("a_vld",    32'(a_out_valid),  32'd1);
    check("a_data",   32'(a_out_data),   32'(d));
    check("a_status", 32'(a_out_status), 32'(st));
    check("a_errpos", 32'(a_out_errpos), 32'(ep));
  endtask

  // Same for the SECDED decoder.
  task automatic b_xfer(input logic [7:0] cw, input logic [3:0] d,
                        input logic [1:0] st, input logic [3:0] ep);
    check("b_rdy", 32'(b_in_ready), 32'd1);
    b_in_valid = 1'b1;
    b_in_cw    = cw;
    @(posedge clock);
    #1 b_in_valid = 1'b0;
    @(negedge clock);
    check("b_lat", 32'(b_out_valid), 32'd0);
    @(negedge clock);
    check("b_vld",    32'(b_out_valid),  32'd1);
    check("b_data",   32'(b_out_data),   32'(d));
    check("b_status", 32'(b_out_status), 32'(st));
    check("b_errpos", 32'(b_out_errpos), 32'(ep));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    a_in_valid  = 1'b0; a_in_cw = '0; a_out_ready = 1'b0; a_clr = 1'b0;
    b_in_valid  = 1'b0; b_in_cw = '0; b_out_ready = 1'b1; b_clr = 1'b0;
    repeat (2) @(negedge clock);

    // Reset state
    check("rst_a_rdy",    32'(a_in_ready),   32'd0);
    check("rst_b_rdy",    32'(b_in_ready),   32'd0);
    check("rst_a_vld",    32'(a_out_valid),  32'd0);
    check("rst_a_data",   32'(a_out_data),   32'd0);
    check("rst_a_status", 32'(a_out_status), 32'd0);
    check("rst_a_errpos", 32'(a_out_errpos), 32'd0);
    check("rst_a_cnt",    32'(a_cnt_corr),   32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rel_a_rdy", 32'(a_in_ready), 32'd1);
    check("rel_b_rdy", 32'(b_in_ready), 32'd1);
    a_out_ready = 1'b1;

    // SEC decoding: clean, parity/data position errors
    a_xfer(7'h55, 4'hB, 2'b00, 4'd0);
    check("t1_cnt", 32'(a_cnt_corr), 32'd0);
    a_xfer(7'h75, 4'hB, 2'b01, 4'd6);
    check("t2_cnt", 32'(a_cnt_corr), 32'd1);
    a_xfer(7'h54, 4'hB, 2'b01, 4'd1);
    a_xfer(7'h04, 4'h0, 2'b01, 4'd3);
    check("sec_cnt3", 32'(a_cnt_corr), 32'd3);

    // Saturation of 2-bit counter
    a_xfer(7'h75, 4'hB, 2'b01, 4'd6);
    a_xfer(7'h75, 4'hB, 2'b01, 4'd6);
    check("sat_cnt",    32'(a_cnt_corr),   32'd3);
    check("sat_uncorr", 32'(a_cnt_uncorr), 32'd0);

    // Clear, then clear coincident with a corrected push
    a_clr = 1'b1;
    @(posedge clock);
    #1 a_clr = 1'b0;
    @(negedge clock);
    check("clr_idle", 32'(a_cnt_corr), 32'd0);
    a_in_valid = 1'b1;
    a_in_cw    = 7'h75;
    @(posedge clock);
    #1 a_in_valid = 1'b0;
    @(negedge clock);
    a_clr = 1'b1;
    @(posedge clock);
    #1 a_clr = 1'b0;
    @(negedge clock);
    check("clr_coinc",      32'(a_cnt_corr), 32'd0);
    check("clr_coinc_vld",  32'(a_out_valid), 32'd1);
    check("clr_coinc_data", 32'(a_out_data),  32'hB);
    a_xfer(7'h75, 4'hB, 2'b01, 4'd6);
    check("post_clr_cnt", 32'(a_cnt_corr), 32'd1);

    // SECDED decoding
    b_xfer(8'h56, 4'hB, 2'b10, 4'd0);
    check("t3_uncorr", 32'(b_cnt_uncorr), 32'd1);
    check("t3_corr0",  32'(b_cnt_corr),   32'd0);
    b_xfer(8'hD5, 4'hB, 2'b01, 4'd8);
    check("t3_corr1",  32'(b_cnt_corr),   32'd1);
    b_xfer(8'h55, 4'hB, 2'b00, 4'd0);
    b_xfer(8'h75, 4'hB, 2'b01, 4'd6);
    check("ded_corr2", 32'(b_cnt_corr),   32'd2);

    // Back-pressure: only FIFO_DEPTH words admitted
    a_out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      if (acc < 6) begin
        a_in_valid = 1'b1;
        a_in_cw    = tbl_cw[acc];
      end else begin
        a_in_valid = 1'b0;
      end
      rdy = a_in_ready;
      @(posedge clock);
      if (rdy && a_in_valid) acc++;
      @(negedge clock);
    end
    a_in_valid = 1'b0;
    check("bp_accepted", 32'(acc),         32'd4);
    check("bp_rdy_low",  32'(a_in_ready),  32'd0);
    check("bp_vld",      32'(a_out_valid), 32'd1);
    a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_vld",  32'(a_out_valid), 32'd1);
      check("drain_data", 32'(a_out_data),  32'(tbl_d[k]));
      @(negedge clock);
    end
    check("drain_empty", 32'(a_out_valid), 32'd0);

    // Sustained one word per clock
    for (int k = 0; k < 6; k++) begin
      if (k >= 2) begin
        check("tput_vld",  32'(a_out_valid), 32'd1);
        check("tput_data", 32'(a_out_data),  32'(tbl_d[(k + 2) % 6]));
      end
      if (k < 4) begin
        check("tput_rdy", 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1;
        a_in_cw    = tbl_cw[(k + 4) % 6];
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clock);
    end
    check("tput_empty", 32'(a_out_valid), 32'd0);

    // Reset with three buffered words
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_cw    = 7'h75;
      @(negedge clock);
    end
    a_in_valid = 1'b0;
    @(negedge clock);
    check("t6_vld",  32'(a_out_valid), 32'd1);
    check("t6_cnt",  32'(a_cnt_corr),  32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_vld",  32'(a_out_valid), 32'd0);
    check("t6_rst_data", 32'(a_out_data),  32'd0);
    check("t6_rst_cnt",  32'(a_cnt_corr),  32'd0);
    check("t6_rst_rdy",  32'(a_in_ready),  32'd0);
    @(negedge clock);
    reset_n     = 1'b1;
    a_out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("t6_stale",    32'(a_out_valid),  32'd0);
    check("t6_a_corr",   32'(a_cnt_corr),   32'd0);
    check("t6_a_uncorr", 32'(a_cnt_uncorr), 32'd0);
    check("t6_b_corr",   32'(b_cnt_corr),   32'd0);
    check("t6_b_uncorr", 32'(b_cnt_uncorr), 32'd0);
    a_xfer(7'h2D, 4'h5, 2'b00, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
